spi_word_rx_controller: RTL

//  Sequences the byte stream from the SPI peripheral (done_rx pulse + received byte) into 32-bit words.

---
 rtl/spi_word_rx_controller.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_word_rx_controller.sv
// Packs SPI receive bytes (MSB first) into words behind a valid/ready output register.
// Optional mid-word stall abort is enabled by defining SPI_RX_TIMEOUT_EN.
module spi_word_rx_controller #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        done_rx,
    input  logic [7:0]  rx_byte,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [7:0]  word_index,
    output logic        frame_err,
    output logic        overrun,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ABORT} state_t;

    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFF >> (8 * (4 - BYTES_PER_WORD));
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    if (BYTES_PER_WORD < 2 || BYTES_PER_WORD > 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("spi_word_rx_controller: illegal parameter value");
    end

    state_t      state;
    logic        armed;
    logic [1:0]  byte_cnt;
    logic [23:0] shift;
    logic [7:0]  next_index;
    logic [31:0] assembled;

`ifdef SPI_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] timer;
`endif

    // Only the last BYTES_PER_WORD bytes shifted in belong to the current word.
    assign assembled = {shift, rx_byte} & WORD_MASK;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            armed      <= 1'b0;
            byte_cnt   <= '0;
            shift      <= '0;
            next_index <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_index <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            if (word_valid && word_ready)
                word_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_n) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state      <= ACTIVE;
                        armed      <= 1'b0;
                        byte_cnt   <= '0;
                        word_index <= '0;
                        next_index <= '0;
                        overrun    <= 1'b0;
`ifdef SPI_RX_TIMEOUT_EN
                        timer      <= '0;
`endif
                    end
                end

                ACTIVE: begin
                    if (cs_n) begin
                        if (byte_cnt != '0)
                            frame_err <= 1'b1;
                        byte_cnt <= '0;
                        armed    <= 1'b1;
                        state    <= IDLE;
                    end else if (done_rx) begin
                        shift <= {shift[15:0], rx_byte};
`ifdef SPI_RX_TIMEOUT_EN
                        timer <= '0;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            // A word accepted this same cycle frees the register for the new one.
                            if (!word_valid || word_ready) begin
                                word_out   <= assembled;
                                word_valid <= 1'b1;
                                word_index <= next_index;
                                next_index <= next_index + 8'd1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
`ifdef SPI_RX_TIMEOUT_EN
                    else if (byte_cnt != '0) begin
                        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            timeout  <= 1'b1;
                            byte_cnt <= '0;
                            timer    <= '0;
                            state    <= ABORT;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
`endif
                end

                ABORT: begin
                    if (cs_n) begin
                        armed <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
